// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
//
// AHB-Lite slave in front of a word-organised on-chip SRAM. It adds a
// programmable number of wait states to each OKAY data phase and can
// optionally answer with a two-cycle ERROR response.
//
// Optional feature macro: AHB_SRAM_ERR_RESP_EN
//   defined   : out-of-range index, oversize hsize and misaligned address
//               give a two-cycle ERROR response and never write.
//   undefined : hresp is tied to OKAY. The index wraps modulo MEM_DEPTH,
//               a misaligned address is aligned down to 2^hsize, and an
//               oversize hsize is treated as a full-word transfer.
//
// Parameters
//   ADDR_WIDTH  : address bus width
//   DATA_WIDTH  : data bus width, 32 or 64
//   MEM_DEPTH   : memory depth in DATA_WIDTH words, power of two
//   WAIT_STATES : stall cycles per OKAY data phase, 0..7
//
// Ports
//   hclk       in  : clock, rising edge
//   hreset     in  : asynchronous active-low reset
//   hsel       in  : slave select
//   haddr      in  : byte address
//   htrans     in  : IDLE/BUSY/NONSEQ/SEQ
//   hwrite     in  : 1 = write
//   hsize      in  : 2^hsize bytes
//   hburst     in  : burst type; accepted, has no effect on behaviour
//   hwdata     in  : write data, valid in the data phase
//   hready_in  in  : bus HREADY (the previous transfer is complete)
//   hreadyout  out : this slave's data-phase ready
//   hrdata     out : read data, non-zero only in the DONE cycle
//   hresp      out : OKAY 00 / ERROR 01
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  output logic                  hreadyout,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic [1:0]            hresp
);

  localparam int         NUM_LANES = DATA_WIDTH / 8;
  localparam int         LANE_BITS = $clog2(NUM_LANES);
  localparam int         IDX_BITS  = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
      $error("ahb_lite_sram_slave: WAIT_STATES must be in 0..7");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("ahb_lite_sram_slave: DATA_WIDTH must be 32 or 64");
    end
    if (MEM_DEPTH < 2 || (1 << IDX_BITS) != MEM_DEPTH) begin : g_bad_depth
      $error("ahb_lite_sram_slave: MEM_DEPTH must be a power of two >= 2");
    end
    if (ADDR_WIDTH <= LANE_BITS + IDX_BITS) begin : g_bad_addr
      $error("ahb_lite_sram_slave: ADDR_WIDTH too small for MEM_DEPTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2
`ifdef AHB_SRAM_ERR_RESP_EN
    ,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [IDX_BITS-1:0]  idx_q;
  logic [NUM_LANES-1:0] be_q;
  logic                 wr_q;
  logic                 take;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address-phase decode -----------------------------------------------------
  logic                 accept;
  logic [2:0]           eff_size;
  logic [LANE_BITS-1:0] size_mask;
  logic [LANE_BITS-1:0] lane_off;
  logic [NUM_LANES-1:0] lane_en;
  logic                 xfer_err;

  assign accept = hsel && hready_in && htrans[1];

  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    lane_en   = '0;
    eff_size  = (hsize > MAX_SIZE) ? MAX_SIZE : hsize;
    size_mask = LANE_BITS'((32'd1 << eff_size) - 32'd1);
    // Aligning down is a no-op for a legal address, so one path serves both
    // builds; the error build rejects misalignment before it matters.
    lane_off  = haddr[LANE_BITS-1:0] & ~size_mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_en[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + (1 << eff_size));
    end
`ifdef AHB_SRAM_ERR_RESP_EN
    xfer_err = (|haddr[ADDR_WIDTH-1:LANE_BITS+IDX_BITS]) ||
               (hsize > MAX_SIZE) ||
               (|(haddr[LANE_BITS-1:0] & size_mask));
`else
    xfer_err = 1'b0;
`endif
  end

  // Next-state logic ---------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ST_DONE;
      end
`ifdef AHB_SRAM_ERR_RESP_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // IDLE, DONE and ERR2 all end a data phase, so a new address phase
        // is taken here with no bubble.
        state_d = ST_IDLE;
        if (accept) begin
          take = 1'b1;
          if (xfer_err) begin
`ifdef AHB_SRAM_ERR_RESP_EN
            state_d = ST_ERR1;
`endif
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q <= haddr[LANE_BITS +: IDX_BITS];
        be_q  <= lane_en;
        wr_q  <= hwrite;
      end
    end
  end

  // NOTE: the array has no reset; clearing it would need a per-word sweep and
  // the contents are defined only by writes. A reset forces the FSM out of
  // DONE at once, so an aborted transfer can never commit.
  always_ff @(posedge hclk) begin
    if (state_q == ST_DONE && wr_q) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Outputs, decoded from the registered state ------------------------------
  always_comb begin
    hreadyout = 1'b1;
    hresp     = 2'b00;
    hrdata    = '0;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_DONE: hrdata    = mem[idx_q];
`ifdef AHB_SRAM_ERR_RESP_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
      end
      ST_ERR2: hresp = 2'b01;
`endif
      default: ;
    endcase
  end

  // Inputs that carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], haddr};

endmodule
